// File: rtl/priority_enc_arb.sv
// priority_enc_arb: registered priority encoder / arbiter for WIDTH request
// lines with a valid/ready output handshake.
// Channel k is D[WIDTH-1-k]: the MSB of D is channel 0. The gnt output uses
// the same bit mapping.
// Optional feature macro: PE_RR_EN. When it is defined, the block gains an
// rr_mode port and a round-robin pointer. When it is undefined, the block is
// fixed-priority only.
module priority_enc_arb #(
  parameter int WIDTH = 8,
  parameter int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
`ifdef PE_RR_EN
  input  logic             rr_mode,
`endif
  input  logic             ready,
  output logic [IW-1:0]    Y,
  output logic [WIDTH-1:0] gnt,
  output logic             valid
);

  logic [IW-1:0]    r_y;
  logic [WIDTH-1:0] r_gnt;
  logic             r_valid;

  logic             w_load;
  logic             w_any;
  logic [WIDTH-1:0] w_req_ch;    // bit k = request of channel k
  logic [IW-1:0]    w_fix_ch;    // lowest-numbered active channel
  logic [IW-1:0]    w_sel_ch;    // channel granted on this load
  logic [WIDTH-1:0] w_gnt_ch;    // one-hot grant, bit k = channel k
  logic [WIDTH-1:0] w_gnt_next;  // one-hot grant in D bit order

  assign Y     = r_y;
  assign gnt   = r_gnt;
  assign valid = r_valid;

  // Outputs may advance when empty or when the consumer takes the current grant.
  always_comb begin
    w_load = !r_valid || ready;
    w_any  = |D;
  end

  // Reorder requests so that bit index equals channel number.
  always_comb begin
    w_req_ch = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_req_ch[k] = D[WIDTH-1-k];
    end
  end

  // Fixed priority: scan from the highest channel down so that the lowest one wins.
  always_comb begin
    w_fix_ch = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (w_req_ch[k]) begin
        w_fix_ch = IW'(k);
      end else begin
        w_fix_ch = w_fix_ch;
      end
    end
  end

`ifdef PE_RR_EN
  logic [IW-1:0]    r_ptr;
  logic [WIDTH-1:0] w_req_rot;   // bit i = channel (ptr + i) mod WIDTH
  logic [IW-1:0]    w_rot_off;   // offset of the first active channel after ptr
  logic [IW:0]      w_rr_sum;
  logic [IW-1:0]    w_rr_ch;
  logic [IW-1:0]    w_ptr_next;

  // Round-robin: rotate requests so that ptr sits at bit 0, pick the first
  // active bit, then map the offset back to a channel number.
  always_comb begin
    w_req_rot = WIDTH'({w_req_ch, w_req_ch} >> r_ptr);
    w_rot_off = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_rot_off = IW'(i);
      end else begin
        w_rot_off = w_rot_off;
      end
    end
    w_rr_sum = {1'b0, r_ptr} + {1'b0, w_rot_off};
    if (w_rr_sum >= (IW+1)'(WIDTH)) begin
      w_rr_ch = IW'(w_rr_sum - (IW+1)'(WIDTH));
    end else begin
      w_rr_ch = w_rr_sum[IW-1:0];
    end
  end

  // Select the arbitration mode and compute the pointer that follows the grant.
  always_comb begin
    if (rr_mode) begin
      w_sel_ch = w_rr_ch;
    end else begin
      w_sel_ch = w_fix_ch;
    end
    if (w_sel_ch == IW'(WIDTH - 1)) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_sel_ch + IW'(1);
    end
  end

  // The pointer moves only when a round-robin grant is loaded.
  // In fixed mode it keeps its saved value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_load && w_any && rr_mode) begin
      r_ptr <= w_ptr_next;
    end else begin
      r_ptr <= r_ptr;
    end
  end
`else
  // Fixed-priority-only build: the lowest active channel always wins.
  always_comb begin
    w_sel_ch = w_fix_ch;
  end
`endif

  // Build the one-hot grant and map it back to D bit order.
  always_comb begin
    w_gnt_ch   = {{(WIDTH-1){1'b0}}, 1'b1} << w_sel_ch;
    w_gnt_next = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_gnt_next[WIDTH-1-k] = w_gnt_ch[k];
    end
  end

  // Output registers: load a new grant, or clear when there is no request.
  // Otherwise hold through a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_y     <= '0;
      r_gnt   <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_y     <= w_sel_ch;
        r_gnt   <= w_gnt_next;
      end else begin
        r_valid <= 1'b0;
        r_y     <= '0;
        r_gnt   <= '0;
      end
    end else begin
      r_valid <= r_valid;
      r_y     <= r_y;
      r_gnt   <= r_gnt;
    end
  end

endmodule

// File: tb/tb_priority_enc_arb.sv
// Self-checking bench for priority_enc_arb (WIDTH=8).
// It covers the fixed-priority scenarios in every build. It also covers the
// round-robin scenarios when PE_RR_EN is defined.
// Expected {valid,Y,gnt} values come from a small reference model. The bench
// pushes them to a queue at drive time and pops them after the next rising edge.
module tb_priority_enc_arb;
  localparam int WIDTH = 8;
  localparam int IW    = 3;
  localparam int OW    = 1 + IW + WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             rr_mode = 1'b0;
  logic             ready = 1'b0;
  logic [WIDTH-1:0] D = '0;
  logic [IW-1:0]    Y;
  logic [WIDTH-1:0] gnt;
  logic             valid;

  int total = 0;
  int bad   = 0;

  logic [OW-1:0] sb[$];
  logic [OW-1:0] exp_v;

  logic             m_valid;
  logic [IW-1:0]    m_y;
  logic [WIDTH-1:0] m_gnt;
  int               m_ptr;

  priority_enc_arb #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .D      (D),
`ifdef PE_RR_EN
    .rr_mode(rr_mode),
`endif
    .ready  (ready),
    .Y      (Y),
    .gnt    (gnt),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid = 1'b0;
    m_y     = '0;
    m_gnt   = '0;
    m_ptr   = 0;
  endtask

  // Drive one cycle of stimulus, update the model, push the expectation, and
  // return 1 time unit after the rising edge.
  task automatic step(input logic [WIDTH-1:0] d, input logic rdy, input logic rr);
    int win;
    int ch;
`ifndef PE_RR_EN
    rr = 1'b0;
`endif
    D       = d;
    ready   = rdy;
    rr_mode = rr;
    if (!m_valid || rdy) begin
      if (d == '0) begin
        m_valid = 1'b0;
        m_y     = '0;
        m_gnt   = '0;
      end else begin
        win = -1;
        for (int j = 0; j < WIDTH; j++) begin
          ch = rr ? (m_ptr + j) % WIDTH : j;
          if (win < 0 && d[WIDTH-1-ch]) win = ch;
        end
        m_valid = 1'b1;
        m_y     = win[IW-1:0];
        m_gnt   = '0;
        m_gnt[WIDTH-1-win] = 1'b1;
        if (rr) m_ptr = (win + 1) % WIDTH;
      end
    end
    sb.push_back({m_valid, m_y, m_gnt});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({valid, Y, gnt} !== {1'b0, 3'd0, 8'h00}) begin
      bad++;
      $display("FAIL reset_async got v=%b Y=%0d gnt=%h want v=0 Y=0 gnt=00", valid, Y, gnt);
    end
    #1 rst = 1'b0;
    model_reset();
    step(8'h00, 1'b1, 1'b0);
    exp_v = sb.pop_front();
    total++;
    if ({valid, Y, gnt} !== exp_v || valid !== 1'b0 || Y !== 3'd0) begin
      bad++;
      $display("FAIL reset_empty got %h want %h", {valid, Y, gnt}, exp_v);
    end
  endtask

  task automatic test_fixed();
    logic [7:0] din[3];
    logic [2:0] ey[3];
    logic [7:0] eg[3];
    din = '{8'h80, 8'h11, 8'h01};
    ey  = '{3'd0, 3'd3, 3'd7};
    eg  = '{8'h80, 8'h10, 8'h01};
    for (int i = 0; i < 3; i++) begin
      step(din[i], 1'b1, 1'b0);
      exp_v = sb.pop_front();
      total++;
      if ({valid, Y, gnt} !== exp_v || {valid, Y, gnt} !== {1'b1, ey[i], eg[i]}) begin
        bad++;
        $display("FAIL fixed_%0d got v=%b Y=%0d gnt=%h want v=1 Y=%0d gnt=%h",
                 i, valid, Y, gnt, ey[i], eg[i]);
      end
    end
  endtask

`ifdef PE_RR_EN
  task automatic test_rr_rotation();
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b1, 1'b1);
      exp_v = sb.pop_front();
      total++;
      if ({valid, Y, gnt} !== exp_v || Y !== 3'(i % 8) || valid !== 1'b1) begin
        bad++;
        $display("FAIL rr_rot_%0d got v=%b Y=%0d want v=1 Y=%0d", i, valid, Y, i % 8);
      end
    end
  endtask

  task automatic test_rr_sparse();
    logic [2:0] ey[4];
    ey = '{3'd0, 3'd7, 3'd0, 3'd7};
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(8'h81, 1'b1, 1'b1);
      exp_v = sb.pop_front();
      total++;
      if ({valid, Y, gnt} !== exp_v || Y !== ey[i]) begin
        bad++;
        $display("FAIL rr_sparse_%0d got Y=%0d want Y=%0d", i, Y, ey[i]);
      end
    end
  endtask
`endif

  task automatic test_stall();
    step(8'h00, 1'b1, 1'b0);
    void'(sb.pop_front());
    step(8'h40, 1'b0, 1'b0);
    exp_v = sb.pop_front();
    total++;
    if ({valid, Y, gnt} !== exp_v || {valid, Y, gnt} !== {1'b1, 3'd1, 8'h40}) begin
      bad++;
      $display("FAIL stall_load got v=%b Y=%0d gnt=%h want v=1 Y=1 gnt=40", valid, Y, gnt);
    end
    for (int i = 0; i < 3; i++) begin
      step(8'h01, 1'b0, 1'b0);
      exp_v = sb.pop_front();
      total++;
      if ({valid, Y, gnt} !== exp_v || {valid, Y, gnt} !== {1'b1, 3'd1, 8'h40}) begin
        bad++;
        $display("FAIL stall_hold_%0d got Y=%0d gnt=%h want Y=1 gnt=40", i, Y, gnt);
      end
    end
    step(8'h01, 1'b1, 1'b0);
    exp_v = sb.pop_front();
    total++;
    if ({valid, Y, gnt} !== exp_v || Y !== 3'd7 || gnt !== 8'h01) begin
      bad++;
      $display("FAIL stall_release got Y=%0d gnt=%h want Y=7 gnt=01", Y, gnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    step(8'h00, 1'b1, 1'b0);
    void'(sb.pop_front());
    step(8'h04, 1'b0, 1'b0);
    exp_v = sb.pop_front();
    total++;
    if ({valid, Y, gnt} !== exp_v || Y !== 3'd5 || valid !== 1'b1) begin
      bad++;
      $display("FAIL midstall_load got v=%b Y=%0d want v=1 Y=5", valid, Y);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({valid, Y, gnt} !== {1'b0, 3'd0, 8'h00}) begin
      bad++;
      $display("FAIL midstall_clear got v=%b Y=%0d gnt=%h want all zero", valid, Y, gnt);
    end
    #1 rst = 1'b0;
    model_reset();
    step(8'hFF, 1'b1, 1'b1);
    exp_v = sb.pop_front();
    total++;
    if ({valid, Y, gnt} !== exp_v || {valid, Y, gnt} !== {1'b1, 3'd0, 8'h80}) begin
      bad++;
      $display("FAIL midstall_after got v=%b Y=%0d gnt=%h want v=1 Y=0 gnt=80", valid, Y, gnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] d;
    logic             rdy;
    logic             rr;
    for (int i = 0; i < 80; i++) begin
      d   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      rr  = 1'($urandom_range(0, 1));
      step(d, rdy, rr);
      exp_v = sb.pop_front();
      total++;
      if ({valid, Y, gnt} !== exp_v) begin
        bad++;
        $display("FAIL b2b_%0d got %h want %h", i, {valid, Y, gnt}, exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fixed();
`ifdef PE_RR_EN
    test_rr_rotation();
    test_rr_sparse();
`endif
    test_stall();
    test_reset_mid_stall();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
